router_fifo: RTL and testbench
==============================

Name: router_fifo

Overview:
Per-destination packet buffer of the 1x3 router. Three instances sit directly downstream of the synchronizer. Each is written via one bit of the synchronizer's one-hot write enable, and each feeds its full/empty status back to the synchronizer for fifo_full, vld_out and soft-reset timing. Every entry stores a header-marker bit, so the read side tracks packet boundaries and flushes cleanly on soft reset.

Parameters:
WIDTH, 8, data byte width.
DEPTH, 16, number of entries (power of two).
ADDR_W, 4, log2(DEPTH).

Ports:
clock  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
soft_reset  input  1  synchronous flush from the synchronizer timeout counter.
write_enb  input  1  write request (one bit of the synchronizer write_enb).
read_enb  input  1  read request from the downstream consumer.
lfd_state  input  1  high when data_in is a packet header byte.
data_in  input  WIDTH  byte to store.
full  output  1  no free entry.
empty  output  1  no stored entry.
data_out  output  WIDTH  registered read data.

Behaviour:
- Storage: DEPTH x (WIDTH+1). Entry = {lfd_state, data_in}.
- Pointers: wr_ptr and rd_ptr are each ADDR_W+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and the low ADDR_W bits are equal.
  - Both are combinational from the registered pointers.
- Priority each cycle: reset > soft_reset > normal operation.
- reset:
  - wr_ptr, rd_ptr and pkt_cnt go to 0. data_out = 0. All memory lfd bits are cleared.
  - After reset: empty=1, full=0.
- soft_reset:
  - Same effect as reset on pointers, pkt_cnt and data_out. Memory contents need not be cleared.
  - A write or read in the same cycle is discarded.
- Write:
  - Accepted when write_enb && !full.
  - Stores {lfd_state, data_in} at wr_ptr[ADDR_W-1:0], then wr_ptr increments with wrap.
  - write_enb while full: no storage, no pointer change.
- Read:
  - Accepted when read_enb && !empty.
  - data_out <= stored byte at rd_ptr, then rd_ptr increments.
  - Latency is 1 cycle: data_out is valid the cycle after read_enb was sampled.
  - read_enb while empty: data_out and rd_ptr hold.
- Packet counter (pkt_cnt, 7 bits):
  - On an accepted read of an entry whose lfd bit is 1: pkt_cnt <= byte[7:2] + 1, i.e. payload length plus the parity byte. Range 1..64.
  - On an accepted read of an entry whose lfd bit is 0 while pkt_cnt != 0: pkt_cnt decrements.
  - pkt_cnt never underflows. A non-header read with pkt_cnt == 0 leaves it at 0.
- End of packet: in the cycle after the read that brings pkt_cnt from 1 to 0, data_out is driven to 0 unless another read is accepted in that cycle.
- Simultaneous read and write:
  - Both succeed when neither blocking condition applies.
  - When full, the read succeeds and the write is dropped, because full is sampled before the update. The count stays DEPTH-1.
  - When empty, the write succeeds and the read is ignored. The count becomes 1.
- Wrap-around: the pointer low bits roll DEPTH-1 -> 0 and the MSB toggles. There is no loss at the boundary.
- Reset mid-packet: the counter and pointers are cleared. The next read of a header byte restarts tracking.

Test Plan:
1. Reset -> empty=1, full=0, data_out=0. Then write header 0x0D (lfd=1, len 3) plus 4 bytes 0x11,0x22,0x33,0x44 -> empty=0, full=0. Read 5 times -> data_out 0x0D,0x11,0x22,0x33,0x44, each one cycle after read_enb. pkt_cnt goes 4,3,2,1,0. data_out=0 the following cycle. empty=1.
2. Write 16 bytes 0x00..0x0F -> full=1 after the 16th write. A 17th write of 0xFF is dropped. Reading all 16 returns 0x00..0x0F. Read with empty=1 -> data_out holds 0x0F and rd_ptr is unchanged.
3. Full FIFO with read_enb=1 and write_enb=1 (data 0xAA) in the same cycle -> read returns the oldest byte, 0xAA is not stored, full=0 next cycle.
4. Wrap: write 10, read 10, write 12, read 12 -> order preserved across pointer wrap. Final empty=1, full=0.
5. Write 6 bytes, read 2, assert soft_reset with write_enb=1 -> next cycle empty=1, data_out=0, the concurrent write is discarded. A fresh header 0x05 written and read gives pkt_cnt=2.
6. Assert reset mid-packet with pkt_cnt=3 -> pointers and pkt_cnt are 0, data_out=0. Reset wins over a simultaneous soft_reset and read_enb.

Source files
------------

// File: rtl/router_fifo_if.sv
// Bus between the synchronizer/consumer and one router_fifo instance.
// The FIFO side is the slave; the driver side (synchronizer or bench) is the master.
interface router_fifo_if #(
  parameter int WIDTH = 8
);
  logic             soft_reset;
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] data_out;

  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  full, empty, data_out
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output full, empty, data_out
  );
endinterface

// File: rtl/router_fifo.sv
// Per-destination packet buffer of the 1x3 router: each entry carries a header
// marker so the read side can count packet bytes and blank data_out at end of packet.
module router_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic          clock,
  input logic          reset,
  router_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic [DEPTH-1:0] r_mem_lfd;
  logic [6:0]       r_pkt_cnt;
  logic             r_eop;
  logic [WIDTH-1:0] r_data_out;

  logic             w_empty;
  logic             w_full;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_rd_lfd;
  logic [WIDTH-1:0] w_rd_byte;
  logic [6:0]       w_hdr_cnt;

  // Wrap bit distinguishes a full FIFO from an empty one when the low bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

  assign w_wr_acc  = bus.write_enb && !w_full;
  assign w_rd_acc  = bus.read_enb  && !w_empty;
  assign w_rd_byte = r_mem_data[r_rd_ptr[ADDR_W-1:0]];
  assign w_rd_lfd  = r_mem_lfd[r_rd_ptr[ADDR_W-1:0]];
  // Header byte[7:2] is the payload length; +1 accounts for the trailing parity byte.
  assign w_hdr_cnt = {1'b0, w_rd_byte[7:2]} + 7'd1;

  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.data_out = r_data_out;

  // NOTE: the data array has no reset so it maps onto plain RAM; only the
  // marker bits are cleared, which is all the packet tracking depends on.
  always_ff @(posedge clock) begin
    if (!reset && !bus.soft_reset && w_wr_acc)
      r_mem_data[r_wr_ptr[ADDR_W-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_mem_lfd <= '0;
    else if (!bus.soft_reset && w_wr_acc)
      r_mem_lfd[r_wr_ptr[ADDR_W-1:0]] <= bus.lfd_state;
  end

  // NOTE: all state here uses non-blocking assignments so every branch sees
  // the pre-edge pointers, which is what makes simultaneous read/write safe.
  always_ff @(posedge clock) begin
    if (reset || bus.soft_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pkt_cnt  <= '0;
      r_eop      <= 1'b0;
      r_data_out <= '0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + PTR_ONE;

      r_eop <= w_rd_acc && !w_rd_lfd && (r_pkt_cnt == 7'd1);

      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_data_out <= w_rd_byte;
        if (w_rd_lfd)
          r_pkt_cnt <= w_hdr_cnt;
        else if (r_pkt_cnt != 7'd0)
          r_pkt_cnt <= r_pkt_cnt - 7'd1;
      end else if (r_eop) begin
        r_data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo with hand-computed expectations.
module tb_router_fifo;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  router_fifo_if #(.WIDTH(8)) bus ();

  router_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic lfd);
    bus.write_enb = 1'b1;
    bus.data_in   = d;
    bus.lfd_state = lfd;
    step();
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    bus.read_enb = 1'b1;
    step();
    bus.read_enb = 1'b0;
    chk(tag, 32'(bus.data_out), 32'(exp));
  endtask

  initial begin
    reset          = 1'b1;
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    bus.read_enb   = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = 8'h00;
    step();
    step();
    reset = 1'b0;

    // 1: reset state, one packet, end-of-packet blanking
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_dout", 32'(bus.data_out), 32'd0);
    wr(8'h0D, 1'b1);
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    wr(8'h33, 1'b0);
    wr(8'h44, 1'b0);
    chk("p1_empty", 32'(bus.empty), 32'd0);
    chk("p1_full", 32'(bus.full), 32'd0);
    rd("p1_hdr", 8'h0D);
    chk("p1_cnt4", 32'(dut.r_pkt_cnt), 32'd4);
    rd("p1_b1", 8'h11);
    chk("p1_cnt3", 32'(dut.r_pkt_cnt), 32'd3);
    rd("p1_b2", 8'h22);
    chk("p1_cnt2", 32'(dut.r_pkt_cnt), 32'd2);
    rd("p1_b3", 8'h33);
    chk("p1_cnt1", 32'(dut.r_pkt_cnt), 32'd1);
    rd("p1_b4", 8'h44);
    chk("p1_cnt0", 32'(dut.r_pkt_cnt), 32'd0);
    step();
    chk("p1_eop_dout", 32'(bus.data_out), 32'd0);
    chk("p1_end_empty", 32'(bus.empty), 32'd1);

    // 2: fill to full, drop overflow write, drain, read while empty
    for (int i = 0; i < 16; i++) begin
      chk("fill_not_full", 32'(bus.full), 32'd0);
      wr(8'(i), 1'b0);
    end
    chk("fill_full", 32'(bus.full), 32'd1);
    wr(8'hFF, 1'b0);
    chk("ovf_wrptr", 32'(dut.r_wr_ptr), 32'd21);
    chk("ovf_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < 16; i++) rd("drain", 8'(i));
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_cnt", 32'(dut.r_pkt_cnt), 32'd0);
    rd("udf_dout", 8'h0F);
    chk("udf_rdptr", 32'(dut.r_rd_ptr), 32'd21);

    // 3: simultaneous read/write while full
    for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i), 1'b0);
    chk("rw_pre_full", 32'(bus.full), 32'd1);
    bus.read_enb  = 1'b1;
    bus.write_enb = 1'b1;
    bus.data_in   = 8'hAA;
    step();
    bus.read_enb  = 1'b0;
    bus.write_enb = 1'b0;
    chk("rw_dout", 32'(bus.data_out), 32'h40);
    chk("rw_full", 32'(bus.full), 32'd0);
    chk("rw_wrptr", 32'(dut.r_wr_ptr), 32'd5);
    for (int i = 1; i < 16; i++) rd("rw_rest", 8'h40 + 8'(i));
    chk("rw_end_empty", 32'(bus.empty), 32'd1);

    // 4: wrap-around ordering
    for (int i = 0; i < 10; i++) wr(8'h60 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) rd("wrap10", 8'h60 + 8'(i));
    for (int i = 0; i < 12; i++) wr(8'h80 + 8'(i), 1'b0);
    for (int i = 0; i < 12; i++) rd("wrap12", 8'h80 + 8'(i));
    chk("wrap_empty", 32'(bus.empty), 32'd1);
    chk("wrap_full", 32'(bus.full), 32'd0);

    // 5: soft reset discards contents and concurrent write
    for (int i = 0; i < 6; i++) wr(8'h90 + 8'(i), 1'b0);
    rd("sr_r0", 8'h90);
    rd("sr_r1", 8'h91);
    bus.soft_reset = 1'b1;
    bus.write_enb  = 1'b1;
    bus.data_in    = 8'hEE;
    step();
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    chk("sr_empty", 32'(bus.empty), 32'd1);
    chk("sr_dout", 32'(bus.data_out), 32'd0);
    chk("sr_wrptr", 32'(dut.r_wr_ptr), 32'd0);
    wr(8'h05, 1'b1);
    rd("sr_hdr", 8'h05);
    chk("sr_cnt", 32'(dut.r_pkt_cnt), 32'd2);

    // 6: hard reset mid-packet beats soft reset and read
    wr(8'h09, 1'b1);
    wr(8'h01, 1'b0);
    wr(8'h02, 1'b0);
    rd("hr_hdr", 8'h09);
    chk("hr_cnt3", 32'(dut.r_pkt_cnt), 32'd3);
    reset          = 1'b1;
    bus.soft_reset = 1'b1;
    bus.read_enb   = 1'b1;
    step();
    reset          = 1'b0;
    bus.soft_reset = 1'b0;
    bus.read_enb   = 1'b0;
    chk("hr_cnt", 32'(dut.r_pkt_cnt), 32'd0);
    chk("hr_wrptr", 32'(dut.r_wr_ptr), 32'd0);
    chk("hr_rdptr", 32'(dut.r_rd_ptr), 32'd0);
    chk("hr_dout", 32'(bus.data_out), 32'd0);
    chk("hr_empty", 32'(bus.empty), 32'd1);
    chk("hr_full", 32'(bus.full), 32'd0);
    wr(8'h0D, 1'b1);
    rd("hr_new_hdr", 8'h0D);
    chk("hr_new_cnt", 32'(dut.r_pkt_cnt), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
